// File: rtl/tron_arena_if.sv
// Pixel write bus from the game engine to the VGA adapter.
// Latency: none, this is plain wiring.
// Backpressure: none. The adapter must accept one pixel on every cycle in which plot is high.
//
// Signals:
//   x, y   : pixel coordinate
//   colour : 3-bit pixel colour
//   plot   : one-cycle write strobe; x, y and colour are valid in the same cycle
interface tron_arena_if;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (output x, y, colour, plot);
    modport slave  (input  x, y, colour, plot);
endinterface

// File: rtl/tron_arena.sv
// N-player light-cycle engine: clears and owns a 1-bit occupancy map, moves heads on a tick, detects crashes.
// Latency: CLEAR takes GRID_W*GRID_H cycles; each live player takes 3 cycles per tick; pixel outputs are registered.
// Backpressure: none. The pixel port is write-only with at most one pixel per cycle; start edges outside IDLE/OVER are dropped.
//
// Ports:
//   CLOCK_50, resetn (synchronous, active-low)
//   start        : level input; its registered rising edge starts a game (from IDLE) or a new clear (from OVER)
//   dir_req      : 4 one-hot bits per player {left, down, up, right}
//   pix          : pixel write bus (x, y, colour, plot)
//   alive        : per-player live flags
//   game_over, winner, winner_valid : result, held until the next start
//   busy         : high while the map is being cleared
module tron_arena #(
    parameter int NUM_PLAYERS = 2,
    parameter int GRID_W      = 160,
    parameter int GRID_H      = 120,
    parameter int X_MIN       = 10,
    parameter int X_MAX       = 150,
    parameter int Y_MIN       = 17,
    parameter int Y_MAX       = 109,
    parameter int TICK_DIV    = 5000000
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [4*NUM_PLAYERS-1:0] dir_req,
    tron_arena_if.master             pix,
    output logic [NUM_PLAYERS-1:0]   alive,
    output logic                     game_over,
    output logic [1:0]               winner,
    output logic                     winner_valid,
    output logic                     busy
);

    localparam int CELLS = GRID_W * GRID_H;
    localparam int AW    = $clog2(CELLS);
    localparam int TW    = $clog2(TICK_DIV);

    localparam logic [7:0] XMIN8 = 8'(X_MIN);
    localparam logic [7:0] XMAX8 = 8'(X_MAX);
    localparam logic [6:0] YMIN7 = 7'(Y_MIN);
    localparam logic [6:0] YMAX7 = 7'(Y_MAX);

    // Heading encoding matches the dir_req bit order, so the reverse of h is ~h.
    localparam logic [1:0] HD_RIGHT = 2'd0;
    localparam logic [1:0] HD_UP    = 2'd1;
    localparam logic [1:0] HD_DOWN  = 2'd2;
    localparam logic [1:0] HD_LEFT  = 2'd3;

    typedef enum logic [2:0] {CLEAR, IDLE, WAIT_TICK, STEP, OVER} state_t;
    typedef enum logic [1:0] {MOVE, READ, COMMIT} phase_t;

    state_t state_q, state_d;
    phase_t phase_q, phase_d;
    logic [1:0] cur_q, cur_d;

    logic start_q1, start_q2, start_edge;

    logic [AW-1:0] clr_addr;
    logic [7:0]    clr_x;
    logic [6:0]    clr_y;
    logic          clr_last;

    logic [TW-1:0] tick_cnt;
    logic          tick_done;

    // Sized for the 4-player maximum so a 2-bit player index never overruns.
    logic [7:0] hx [0:3];
    logic [6:0] hy [0:3];
    logic [1:0] hd [0:3];

    logic [7:0] nxt_x;
    logic [6:0] nxt_y;
    logic       inb_q;
    logic       occ_rd_q;
    logic       occ_mem [0:CELLS-1];

    logic [7:0] px_x;
    logic [6:0] px_y;
    logic [2:0] px_col;
    logic       px_plot;

    logic [15:0] dir_all;
    logic [3:0]  req;
    logic        req_ok;
    logic [1:0]  req_dir;
    logic [1:0]  new_hd;
    logic [7:0]  mv_x;
    logic [6:0]  mv_y;

    logic          in_grid, in_bounds, kill;
    logic [AW-1:0] pos_addr;
    logic          occ_we, occ_wd;
    logic [AW-1:0] occ_wa;

    logic [NUM_PLAYERS-1:0] alive_after;
    logic [1:0] first_idx, nxt_idx, win_idx;
    logic       nxt_found;
    logic [2:0] n_live;

    assign pix.x      = px_x;
    assign pix.y      = px_y;
    assign pix.colour = px_col;
    assign pix.plot   = px_plot;

    assign busy       = (state_q == CLEAR);
    assign start_edge = start_q1 & ~start_q2;
    assign clr_last   = (clr_addr == AW'(CELLS - 1));
    assign tick_done  = (tick_cnt == TW'(TICK_DIV - 1));
    assign dir_all    = 16'(dir_req);
    assign req        = dir_all[{cur_q, 2'b00} +: 4];

    // MOVE: turn acceptance and next head position (mod 2^8 / 2^7).
    always_comb begin
        req_ok  = (req != 4'd0) && ((req & (req - 4'd1)) == 4'd0);
        req_dir = HD_RIGHT;
        case (req)
            4'b0010: req_dir = HD_UP;
            4'b0100: req_dir = HD_DOWN;
            4'b1000: req_dir = HD_LEFT;
            default: req_dir = HD_RIGHT;
        endcase
        new_hd = hd[cur_q];
        if (req_ok && (req_dir != ~hd[cur_q]))
            new_hd = req_dir;
        mv_x = hx[cur_q];
        mv_y = hy[cur_q];
        case (new_hd)
            HD_RIGHT: mv_x = hx[cur_q] + 8'd1;
            HD_UP:    mv_y = hy[cur_q] - 7'd1;
            HD_DOWN:  mv_y = hy[cur_q] + 7'd1;
            default:  mv_x = hx[cur_q] - 8'd1;
        endcase
    end

    // Wrapped coordinates can leave the grid; the address is parked at 0 then,
    // which is harmless because the bounds check already fails.
    assign in_grid   = ({1'b0, nxt_x} < 9'(GRID_W)) && ({1'b0, nxt_y} < 8'(GRID_H));
    assign pos_addr  = in_grid ? AW'(int'(nxt_x) * GRID_H + int'(nxt_y)) : '0;
    assign in_bounds = (nxt_x >= XMIN8) && (nxt_x <= XMAX8) &&
                       (nxt_y >= YMIN7) && (nxt_y <= YMAX7);
    assign kill      = !inb_q || occ_rd_q;

    assign occ_we = (state_q == CLEAR) || ((state_q == STEP) && (phase_q == COMMIT) && !kill);
    assign occ_wa = (state_q == CLEAR) ? clr_addr : pos_addr;
    assign occ_wd = (state_q != CLEAR);

    // Player scheduling: dead players are skipped by jumping straight to the next live index.
    always_comb begin
        alive_after = alive;
        first_idx   = 2'd0;
        nxt_found   = 1'b0;
        nxt_idx     = 2'd0;
        win_idx     = 2'd0;
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            if (kill && (j == int'(cur_q)))
                alive_after[j] = 1'b0;
        end
        for (int j = NUM_PLAYERS - 1; j >= 0; j--) begin
            if (alive[j])
                first_idx = 2'(j);
            if (alive[j] && (j > int'(cur_q))) begin
                nxt_found = 1'b1;
                nxt_idx   = 2'(j);
            end
            if (alive_after[j])
                win_idx = 2'(j);
        end
        n_live = 3'($countones(alive_after));
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q <= CLEAR;
            phase_q <= MOVE;
            cur_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cur_q   <= cur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cur_d   = cur_q;
        case (state_q)
            CLEAR:     if (clr_last) state_d = IDLE;
            IDLE:      if (start_edge) state_d = WAIT_TICK;
            WAIT_TICK: begin
                if (tick_done) begin
                    state_d = STEP;
                    phase_d = MOVE;
                    cur_d   = first_idx;
                end
            end
            STEP: begin
                case (phase_q)
                    MOVE:    phase_d = READ;
                    READ:    phase_d = COMMIT;
                    default: begin
                        phase_d = MOVE;
                        if (nxt_found)
                            cur_d = nxt_idx;
                        else if (n_live <= 3'd1)
                            state_d = OVER;
                        else
                            state_d = WAIT_TICK;
                    end
                endcase
            end
            OVER:      if (start_edge) state_d = CLEAR;
            default:   state_d = CLEAR;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            start_q1     <= 1'b0;
            start_q2     <= 1'b0;
            clr_addr     <= '0;
            clr_x        <= 8'd0;
            clr_y        <= 7'd0;
            tick_cnt     <= '0;
            px_plot      <= 1'b0;
            px_x         <= 8'd0;
            px_y         <= 7'd0;
            px_col       <= 3'd0;
            alive        <= '0;
            game_over    <= 1'b0;
            winner       <= 2'd0;
            winner_valid <= 1'b0;
            nxt_x        <= 8'd0;
            nxt_y        <= 7'd0;
            inb_q        <= 1'b0;
        end else begin
            start_q1 <= start;
            start_q2 <= start_q1;
            px_plot  <= 1'b0;
            tick_cnt <= ((state_q == WAIT_TICK) && !tick_done) ? tick_cnt + TW'(1) : '0;
            case (state_q)
                CLEAR: begin
                    px_plot <= 1'b1;
                    px_x    <= clr_x;
                    px_y    <= clr_y;
                    px_col  <= 3'd0;
                    if (clr_last) begin
                        clr_addr <= '0;
                        clr_x    <= 8'd0;
                        clr_y    <= 7'd0;
                        alive    <= '1;
                        for (int i = 0; i < 4; i++) begin
                            hx[i] <= (i < NUM_PLAYERS) ? 8'(GRID_W * (i + 1) / (NUM_PLAYERS + 1)) : 8'd0;
                            hy[i] <= 7'(GRID_H / 4);
                            hd[i] <= HD_DOWN;
                        end
                    end else begin
                        clr_addr <= clr_addr + AW'(1);
                        if (clr_y == 7'(GRID_H - 1)) begin
                            clr_y <= 7'd0;
                            clr_x <= clr_x + 8'd1;
                        end else begin
                            clr_y <= clr_y + 7'd1;
                        end
                    end
                end
                STEP: begin
                    case (phase_q)
                        MOVE: begin
                            hd[cur_q] <= new_hd;
                            nxt_x     <= mv_x;
                            nxt_y     <= mv_y;
                        end
                        READ: inb_q <= in_bounds;
                        default: begin
                            alive <= alive_after;
                            if (!kill) begin
                                hx[cur_q] <= nxt_x;
                                hy[cur_q] <= nxt_y;
                                px_plot   <= 1'b1;
                                px_x      <= nxt_x;
                                px_y      <= nxt_y;
                                px_col    <= {1'b0, cur_q} + 3'd1;
                            end
                            if (state_d == OVER) begin
                                game_over    <= 1'b1;
                                winner       <= win_idx;
                                winner_valid <= (n_live == 3'd1);
                            end
                        end
                    endcase
                end
                OVER: begin
                    if (start_edge) begin
                        game_over    <= 1'b0;
                        winner_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Occupancy map: one write port, one read port with one cycle of latency.
    always_ff @(posedge CLOCK_50) begin
        if (occ_we)
            occ_mem[occ_wa] <= occ_wd;
        occ_rd_q <= occ_mem[pos_addr];
    end

endmodule

// File: tb/tb_tron_arena.sv
// Directed bench for tron_arena: map clear, turn filtering, reset abort, head-on draw and wall crash.
// Latency: samples every output on the falling edge, half a cycle after the registered update.
// Backpressure: none; every wait on the DUT is bounded by a cycle budget.
module tb_tron_arena;

    logic       CLOCK_50;
    logic       resetn;
    logic       start;
    logic [7:0] dir_req;
    logic [1:0] alive;
    logic       game_over;
    logic [1:0] winner;
    logic       winner_valid;
    logic       busy;

    tron_arena_if pif();

    tron_arena #(
        .NUM_PLAYERS (2),
        .TICK_DIV    (16)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .start        (start),
        .dir_req      (dir_req),
        .pix          (pif),
        .alive        (alive),
        .game_over    (game_over),
        .winner       (winner),
        .winner_valid (winner_valid),
        .busy         (busy)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic wait_plot(output logic [7:0] px, output logic [6:0] py,
                             output logic [2:0] pc, output logic got);
        got = 1'b0;
        px  = 8'd0;
        py  = 7'd0;
        pc  = 3'd0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK_50);
            if (pif.plot) begin
                got = 1'b1;
                px  = pif.x;
                py  = pif.y;
                pc  = pif.colour;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic wait_clear(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge CLOCK_50);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, 32'(done), 32'd1);
        @(negedge CLOCK_50);
    endtask

    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
    logic       got;
    int         nbusy, nplot, nbadcol, nplot_end;
    logic [7:0] lx;
    logic [6:0] ly;
    logic       over_seen;

    initial begin
        resetn  = 1'b0;
        start   = 1'b0;
        dir_req = 8'd0;
        repeat (3) @(negedge CLOCK_50);

        chk("rst_busy",   32'(busy),         32'd1);
        chk("rst_plot",   32'(pif.plot),     32'd0);
        chk("rst_x",      32'(pif.x),        32'd0);
        chk("rst_y",      32'(pif.y),        32'd0);
        chk("rst_colour", 32'(pif.colour),   32'd0);
        chk("rst_alive",  32'(alive),        32'd0);
        chk("rst_over",   32'(game_over),    32'd0);
        chk("rst_winner", 32'(winner),       32'd0);
        chk("rst_wvalid", 32'(winner_valid), 32'd0);

        // Map clear after reset release.
        resetn    = 1'b1;
        nbusy     = 0;
        nplot     = 0;
        nbadcol   = 0;
        lx        = 8'd0;
        ly        = 7'd0;
        for (int i = 0; i < 20000; i++) begin
            if (busy) nbusy++;
            if (pif.plot) begin
                nplot++;
                if (pif.colour != 3'd0) nbadcol++;
                lx = pif.x;
                ly = pif.y;
            end
            if (i > 0 && !busy && !pif.plot) break;
            @(negedge CLOCK_50);
        end
        chk("clr_busy_cycles", 32'(nbusy),   32'd19200);
        chk("clr_plots",       32'(nplot),   32'd19200);
        chk("clr_colour",      32'(nbadcol), 32'd0);
        chk("clr_last_x",      32'(lx),      32'd159);
        chk("clr_last_y",      32'(ly),      32'd119);
        chk("clr_busy_after",  32'(busy),    32'd0);
        chk("clr_alive",       32'(alive),   32'd3);

        // Game A: two-bit request then reverse request are both ignored.
        dir_req = 8'b0000_0011;
        pulse_start();
        wait_plot(px, py, pc, got);
        chk("a_t1_p0_got", 32'(got), 32'd1);
        chk("a_t1_p0_x",   32'(px),  32'd53);
        chk("a_t1_p0_y",   32'(py),  32'd31);
        chk("a_t1_p0_col", 32'(pc),  32'd1);
        wait_plot(px, py, pc, got);
        chk("a_t1_p1_got", 32'(got), 32'd1);
        chk("a_t1_p1_x",   32'(px),  32'd106);
        chk("a_t1_p1_y",   32'(py),  32'd31);
        chk("a_t1_p1_col", 32'(pc),  32'd2);
        dir_req = 8'b0000_0010;
        wait_plot(px, py, pc, got);
        chk("a_t2_p0_got", 32'(got), 32'd1);
        chk("a_t2_p0_x",   32'(px),  32'd53);
        chk("a_t2_p0_y",   32'(py),  32'd32);
        chk("a_t2_p0_col", 32'(pc),  32'd1);

        // Reset pulse while player 1 is still mid-step.
        resetn = 1'b0;
        @(negedge CLOCK_50);
        chk("mid_rst_busy",  32'(busy),      32'd1);
        chk("mid_rst_plot",  32'(pif.plot),  32'd0);
        chk("mid_rst_alive", 32'(alive),     32'd0);
        chk("mid_rst_over",  32'(game_over), 32'd0);
        resetn  = 1'b1;
        dir_req = 8'd0;
        @(negedge CLOCK_50);
        chk("mid_rst_plot1", 32'(pif.plot),   32'd1);
        chk("mid_rst_x",     32'(pif.x),      32'd0);
        chk("mid_rst_y",     32'(pif.y),      32'd0);
        chk("mid_rst_col",   32'(pif.colour), 32'd0);
        chk("mid_rst_busy1", 32'(busy),       32'd1);
        wait_clear("b_clear_done");

        // Game B: head-on, both die on tick 27.
        dir_req = 8'b1000_0001;
        pulse_start();
        for (int t = 1; t <= 26; t++) begin
            wait_plot(px, py, pc, got);
            chk($sformatf("b_t%0d_p0_x", t),   32'(got ? px : 8'hff), 32'(53 + t));
            chk($sformatf("b_t%0d_p0_col", t), 32'(pc),               32'd1);
            wait_plot(px, py, pc, got);
            chk($sformatf("b_t%0d_p1_x", t),   32'(got ? px : 8'hff), 32'(106 - t));
            chk($sformatf("b_t%0d_p1_col", t), 32'(pc),               32'd2);
        end
        over_seen = 1'b0;
        nplot_end = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK_50);
            if (pif.plot) nplot_end++;
            if (game_over) begin
                over_seen = 1'b1;
                break;
            end
        end
        chk("b_over",   32'(over_seen),    32'd1);
        chk("b_plots",  32'(nplot_end),    32'd0);
        chk("b_alive",  32'(alive),        32'd0);
        chk("b_wvalid", 32'(winner_valid), 32'd0);
        repeat (5) @(negedge CLOCK_50);
        chk("b_hold_over", 32'(game_over), 32'd1);

        // Start from OVER begins a fresh clear.
        pulse_start();
        chk("b_restart_busy",   32'(busy),         32'd1);
        chk("b_restart_over",   32'(game_over),    32'd0);
        chk("b_restart_wvalid", 32'(winner_valid), 32'd0);
        wait_clear("c_clear_done");

        // Game C: player 0 turns left and hits the x=9 wall on tick 44.
        dir_req = 8'b0000_1000;
        pulse_start();
        for (int t = 1; t <= 43; t++) begin
            wait_plot(px, py, pc, got);
            chk($sformatf("c_t%0d_p0_x", t),   32'(got ? px : 8'hff), 32'(53 - t));
            chk($sformatf("c_t%0d_p0_y", t),   32'(py),               32'd30);
            chk($sformatf("c_t%0d_p0_col", t), 32'(pc),               32'd1);
            wait_plot(px, py, pc, got);
            chk($sformatf("c_t%0d_p1_y", t),   32'(got ? py : 7'h7f), 32'(30 + t));
        end
        wait_plot(px, py, pc, got);
        chk("c_t44_got",  32'(got), 32'd1);
        chk("c_t44_col",  32'(pc),  32'd2);
        chk("c_t44_x",    32'(px),  32'd106);
        chk("c_t44_y",    32'(py),  32'd74);
        repeat (2) @(negedge CLOCK_50);
        chk("c_alive",  32'(alive),        32'd2);
        chk("c_over",   32'(game_over),    32'd1);
        chk("c_winner", 32'(winner),       32'd1);
        chk("c_wvalid", 32'(winner_valid), 32'd1);
        chk("c_busy",   32'(busy),         32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
